// File: rtl/hack_sequencer.sv
// hack_sequencer: multi-cycle control sequencer for the Hack CPU datapath.
// Fetches over a ROM req/valid handshake, accesses data memory over a
// req/ack handshake, and drives the datapath enables one phase at a time.
// A per-wait watchdog forces ERR when a handshake stalls TIMEOUT cycles.
// Optional feature macro: HACK_SEQ_PERF_CNT_EN enables the retired
// instruction counter on instr_count (tied to 0 otherwise).
//
// Handshake semantics: a request (rom_req, mem_rd_req, mem_wr_req) is a
// level asserted from state entry up to and including the cycle in which
// its completion (rom_valid / mem_ack) is seen; completion is accepted in
// that same cycle, the load pulse fires in it, and the state advances on
// the following edge. A completion seen outside its matching state is ignored.
module hack_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    input  logic [15:0] instr,
    input  logic        rom_valid,
    input  logic        mem_ack,
    input  logic        Zy,
    input  logic        Cy,
    output logic        rom_req,
    output logic        ir_load,
    output logic        mem_rd_req,
    output logic        mdr_load,
    output logic        mem_wr_req,
    output logic        we_a,
    output logic        we_d,
    output logic        we_m,
    output logic        a_imm,
    output logic        a,
    output logic        PC_e,
    output logic        pc_load,
    output logic        halted,
    output logic        err,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_MREAD  = 3'd2,
        S_MWRITE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Last wait count before the watchdog fires; ERR follows TIMEOUT stalled cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;
    logic [7:0]  wait_q;
    logic        wait_last;
    logic        waiting;
    logic        jump;
    logic        unused_ir_bits;

    assign wait_last = (wait_q == WAIT_LAST);
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MREAD) || (state_q == S_MWRITE);
    assign dbg_state = state_q;

    // Jump only for C-instructions; flags are sampled live during EXEC.
    assign jump = ir_q[15] & ((ir_q[2] & Cy) | (ir_q[1] & Zy) | (ir_q[0] & ~Cy & ~Zy));

    // IR bits not involved in sequencing (ALU function and A/C filler bits).
    assign unused_ir_bits = ^{ir_q[14:13], ir_q[11:6]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a completing handshake takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (rom_valid) begin
                    if (!instr[15])     state_d = S_EXEC;
                    else if (instr[12]) state_d = S_MREAD;
                    else if (instr[3])  state_d = S_MWRITE;
                    else                state_d = S_EXEC;
                end else if (wait_last) begin
                    state_d = S_ERR;
                end
            end
            S_MREAD: begin
                if (mem_ack)        state_d = ir_q[3] ? S_MWRITE : S_EXEC;
                else if (wait_last) state_d = S_ERR;
            end
            S_MWRITE: begin
                if (mem_ack)        state_d = S_EXEC;
                else if (wait_last) state_d = S_ERR;
            end
            S_EXEC:   state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT:   if (run && !halt_req) state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
    end

    // IR capture on fetch completion and watchdog counter (cleared on every state entry).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q   <= 16'h0000;
            wait_q <= 8'h00;
        end else begin
            if (state_q == S_FETCH && rom_valid) ir_q <= instr;
            if (state_d != state_q) wait_q <= 8'h00;
            else if (waiting)       wait_q <= wait_q + 8'd1;
        end
    end

    // Output decode per phase; everything defaults low.
    always_comb begin
        rom_req    = 1'b0;
        ir_load    = 1'b0;
        mem_rd_req = 1'b0;
        mdr_load   = 1'b0;
        mem_wr_req = 1'b0;
        we_a       = 1'b0;
        we_d       = 1'b0;
        we_m       = 1'b0;
        a_imm      = 1'b0;
        a          = 1'b0;
        PC_e       = 1'b0;
        pc_load    = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy    = 1'b1;
                rom_req = 1'b1;
                ir_load = rom_valid;
            end
            S_MREAD: begin
                busy       = 1'b1;
                mem_rd_req = 1'b1;
                mdr_load   = mem_ack;
            end
            S_MWRITE: begin
                busy       = 1'b1;
                mem_wr_req = 1'b1;
                we_m       = 1'b1;
                a          = ir_q[12];
            end
            S_EXEC: begin
                busy = 1'b1;
                if (!ir_q[15]) begin
                    we_a  = 1'b1;
                    a_imm = 1'b1;
                    PC_e  = 1'b1;
                end else begin
                    we_a    = ir_q[5];
                    we_d    = ir_q[4];
                    a       = ir_q[12];
                    pc_load = jump;
                    PC_e    = ~jump;
                end
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err    = 1'b1;
            default: ;
        endcase
    end

`ifdef HACK_SEQ_PERF_CNT_EN
    logic [31:0] count_q;

    // Retired-instruction counter; advances at the end of each EXEC cycle, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  count_q <= 32'h0000_0000;
        else if (state_q == S_EXEC) count_q <= count_q + 32'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_hack_sequencer.sv
// tb_hack_sequencer: directed and randomized checks of hack_sequencer
// against a phase-level reference model of the instruction sequencing.
module tb_hack_sequencer;

    localparam int TB_TIMEOUT = 4;

    localparam logic [14:0] V_ROM  = 15'h4000;
    localparam logic [14:0] V_IRL  = 15'h2000;
    localparam logic [14:0] V_RD   = 15'h1000;
    localparam logic [14:0] V_MDR  = 15'h0800;
    localparam logic [14:0] V_WR   = 15'h0400;
    localparam logic [14:0] V_WA   = 15'h0200;
    localparam logic [14:0] V_WD   = 15'h0100;
    localparam logic [14:0] V_WM   = 15'h0080;
    localparam logic [14:0] V_IMM  = 15'h0040;
    localparam logic [14:0] V_A    = 15'h0020;
    localparam logic [14:0] V_PCE  = 15'h0010;
    localparam logic [14:0] V_PCL  = 15'h0008;
    localparam logic [14:0] V_HALT = 15'h0004;
    localparam logic [14:0] V_ERR  = 15'h0002;
    localparam logic [14:0] V_BUSY = 15'h0001;

    logic        clk = 1'b0;
    logic        rst, run, halt_req, rom_valid, mem_ack, Zy, Cy;
    logic [15:0] instr;
    logic        rom_req, ir_load, mem_rd_req, mdr_load, mem_wr_req;
    logic        we_a, we_d, we_m, a_imm, a, PC_e, pc_load;
    logic        halted, err, busy;
    logic [31:0] instr_count;
    logic [2:0]  dbg_state;
    logic [14:0] obs;

    int          errors = 0;
    int          checks = 0;
    int unsigned retired = 0;
    logic [14:0] exp_q[$];

    hack_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .instr(instr),
        .rom_valid(rom_valid), .mem_ack(mem_ack), .Zy(Zy), .Cy(Cy),
        .rom_req(rom_req), .ir_load(ir_load), .mem_rd_req(mem_rd_req),
        .mdr_load(mdr_load), .mem_wr_req(mem_wr_req), .we_a(we_a), .we_d(we_d),
        .we_m(we_m), .a_imm(a_imm), .a(a), .PC_e(PC_e), .pc_load(pc_load),
        .halted(halted), .err(err), .busy(busy), .instr_count(instr_count),
        .dbg_state(dbg_state)
    );

    assign obs = {rom_req, ir_load, mem_rd_req, mdr_load, mem_wr_req, we_a, we_d,
                  we_m, a_imm, a, PC_e, pc_load, halted, err, busy};

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_count();
`ifdef HACK_SEQ_PERF_CNT_EN
        return retired;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_vec(input string tag, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outputs observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [31:0] exp;
        exp = exp_count();
        checks++;
        assert (instr_count === exp) else begin
            errors++;
            $error("FAIL %s count: observed=%0d expected=%0d", tag, instr_count, exp);
        end
    endtask

    // One clock: inputs already driven; compare at negedge against the scoreboard head.
    task automatic step(input string tag);
        @(negedge clk);
        check_vec(tag, exp_q.pop_front());
        check_cnt(tag);
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction from FETCH to the end of EXEC, building expectations
    // from the instruction's fields: which memory phases it needs and what EXEC does.
    task automatic run_instr(input logic [15:0] i, input int rom_w, input int rd_w,
                             input int wr_w, input logic zy, input logic cy,
                             input logic hlt);
        logic        is_c, need_rd, need_wr, jmp;
        logic [14:0] ev;
        is_c    = i[15];
        need_rd = is_c & i[12];
        need_wr = is_c & i[3];
        for (int k = 0; k <= rom_w; k++) begin
            rom_valid = (k == rom_w);
            instr     = (k == rom_w) ? i : 16'($urandom);
            mem_ack   = 1'($urandom);
            run       = 1'($urandom);
            halt_req  = 1'($urandom);
            Zy        = 1'($urandom);
            Cy        = 1'($urandom);
            exp_q.push_back(V_ROM | V_BUSY | ((k == rom_w) ? V_IRL : 15'h0));
            step("fetch");
        end
        rom_valid = 1'b0;
        if (need_rd) begin
            for (int k = 0; k <= rd_w; k++) begin
                mem_ack   = (k == rd_w);
                rom_valid = 1'($urandom);
                run       = 1'($urandom);
                exp_q.push_back(V_RD | V_BUSY | ((k == rd_w) ? V_MDR : 15'h0));
                step("mread");
            end
        end
        if (need_wr) begin
            for (int k = 0; k <= wr_w; k++) begin
                mem_ack   = (k == wr_w);
                rom_valid = 1'($urandom);
                run       = 1'($urandom);
                exp_q.push_back(V_WR | V_WM | V_BUSY | (i[12] ? V_A : 15'h0));
                step("mwrite");
            end
        end
        Zy        = zy;
        Cy        = cy;
        halt_req  = hlt;
        mem_ack   = 1'($urandom);
        rom_valid = 1'($urandom);
        run       = 1'($urandom);
        if (!is_c) begin
            ev = V_WA | V_IMM | V_PCE | V_BUSY;
        end else begin
            jmp = (i[2] && cy) || (i[1] && zy) || (i[0] && !cy && !zy);
            ev  = V_BUSY | (i[5] ? V_WA : 15'h0) | (i[4] ? V_WD : 15'h0) |
                  (i[12] ? V_A : 15'h0) | (jmp ? V_PCL : V_PCE);
        end
        exp_q.push_back(ev);
        step("exec");
        retired++;
        mem_ack   = 1'b0;
        rom_valid = 1'b0;
        halt_req  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; instr = 16'h0;
        rom_valid = 1'b0; mem_ack = 1'b0; Zy = 1'b0; Cy = 1'b0;
        #2;
        check_vec("reset", 15'h0);
        check_cnt("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE -> FETCH.
        run = 1'b1;
        exp_q.push_back(15'h0);
        step("idle");

        // Directed instructions.
        run_instr(16'h0056, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16'h8045, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(16'h813B, 0, 0, 3, 1'b1, 1'b0, 1'b0);
        run_instr(16'h9010, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16'h9018, 1, 2, 1, 1'b0, 1'b1, 1'b0);

        // Randomized instructions with bounded handshake delays.
        for (int n = 0; n < 40; n++) begin
            run_instr(16'($urandom), $urandom_range(0, TB_TIMEOUT - 1),
                      $urandom_range(0, TB_TIMEOUT - 1), $urandom_range(0, TB_TIMEOUT - 1),
                      1'($urandom), 1'($urandom), 1'b0);
        end

        // Halt and resume.
        run_instr(16'h0056, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        run = 1'b1; halt_req = 1'b1;
        exp_q.push_back(V_HALT);
        step("halt_hold");
        run = 1'b0; halt_req = 1'b0;
        exp_q.push_back(V_HALT);
        step("halt_norun");
        run = 1'b1; halt_req = 1'b0;
        exp_q.push_back(V_HALT);
        step("halt_release");
        run_instr(16'h8045, 0, 0, 0, 1'b0, 1'b1, 1'b0);

        // Watchdog: ROM never answers.
        rom_valid = 1'b0;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            exp_q.push_back(V_ROM | V_BUSY);
            step("wd_fetch");
        end
        for (int k = 0; k < 3; k++) begin
            run       = 1'b1;
            rom_valid = 1'($urandom);
            mem_ack   = 1'($urandom);
            exp_q.push_back(V_ERR);
            step("err_sticky");
        end

        // Asynchronous reset out of ERR, then again in the middle of MWRITE.
        #2 rst = 1'b1;
        retired = 0;
        #1;
        check_vec("rst_err", 15'h0);
        check_cnt("rst_err");
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b1; rom_valid = 1'b0; mem_ack = 1'b0;
        exp_q.push_back(15'h0);
        step("idle2");
        rom_valid = 1'b1; instr = 16'h8008;
        exp_q.push_back(V_ROM | V_IRL | V_BUSY);
        step("fetch_mw");
        rom_valid = 1'b0; mem_ack = 1'b0;
        exp_q.push_back(V_WR | V_WM | V_BUSY);
        step("mwrite_pending");
        #2 rst = 1'b1;
        #1;
        check_vec("rst_mwrite", 15'h0);
        check_cnt("rst_mwrite");
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
